desc_batch_drain: RTL and testbench

DESC_BATCH_DRAIN -- requirements
Module: desc_batch_drain

---
 rtl/desc_batch_drain_pkg.sv | 11 +
 rtl/desc_skid2.sv | 33 +++
 rtl/desc_batch_drain.sv | 81 ++++++++
 tb/tb_desc_batch_drain.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/desc_batch_drain_pkg.sv
// desc_batch_drain_pkg: shared FSM states, batch default and FIFO count helper
//   BATCH_SIZE_DEF : default maximum number of descriptors per batch
//   state_t        : drain FSM states (IDLE, RUN, STALL)
//   cnt_next       : next occupancy of the two-entry output FIFO
package desc_batch_drain_pkg;
   localparam int BATCH_SIZE_DEF = 8;
   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
   function automatic logic [1:0] cnt_next(logic [1:0] cnt, logic push, logic pop);
      return cnt + 2'(push) - 2'(pop);
   endfunction
endpackage

// File: rtl/desc_skid2.sv
// desc_skid2: two-entry order-preserving FIFO with registered head
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data this cycle (never while full unless popping)
//   pop       : remove head this cycle (only while cnt != 0)
//   push_data : entry to write
//   cnt       : entries held, 0..2
//   head      : oldest entry, meaningful while cnt != 0
module desc_skid2 import desc_batch_drain_pkg::*; #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [1:0]   cnt,
   output logic [W-1:0] head
);
   logic [W-1:0] tail;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         cnt <= cnt_next(cnt, push, pop);
         // head refills from tail when two were held, else straight from the write
         if (pop && cnt == 2'd2) head <= tail;
         else if (push && (cnt == 2'd0 || pop)) head <= push_data;
         if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) tail <= push_data;
      end
   end
endmodule

// File: rtl/desc_batch_drain.sv
// desc_batch_drain: drains a prefetching ring buffer into batches of descriptors
//   clk, rst   : clock, synchronous active-high reset
//   rb_rd_data : ring head entry, valid while the ring is non-empty
//   rb_rd_en   : pop the ring head this cycle
//   rb_occup   : ring occupancy, already net of this cycle's pop
//   out_data   : descriptor to downstream
//   out_valid  : out_data valid
//   out_ready  : downstream accepts
//   out_last   : final descriptor of the current batch
//   batch_cnt  : completed batches (accepted beats with out_last), wraps
module desc_batch_drain import desc_batch_drain_pkg::*; #(
   parameter int DWIDTH     = 64,
   parameter int AWIDTH     = 9,
   parameter int BATCH_SIZE = BATCH_SIZE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] rb_rd_data,
   output logic              rb_rd_en,
   input  logic [AWIDTH-1:0] rb_occup,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [31:0]       batch_cnt
);
   logic [AWIDTH-1:0] occ_q;
   logic [7:0]        in_batch;
   logic [1:0]        fifo_cnt;
   logic [1:0]        cnt_nxt;
   logic [DWIDTH:0]   head;
   logic [31:0]       batch_q;
   logic              rd;
   logic              pop;
   logic              last_in;
   state_t            state;
   state_t            state_nxt;
   // read decision uses only registered occupancy, so no rb_occup->rb_rd_en path
   assign rd      = !rst && occ_q != '0 && fifo_cnt < 2'd2 && (state != IDLE || occ_q != '0);
   assign pop     = !rst && fifo_cnt != 2'd0 && out_ready;
   // close the batch at its size limit, or when this read empties the ring
   assign last_in = in_batch == 8'(BATCH_SIZE - 1) || rb_occup == '0;
   assign cnt_nxt = cnt_next(fifo_cnt, rd, pop);
   desc_skid2 #(.W(DWIDTH + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd),
      .pop       (pop),
      .push_data ({last_in, rb_rd_data}),
      .cnt       (fifo_cnt),
      .head      (head)
   );
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = occ_q != '0 ? RUN : IDLE;
         RUN:     state_nxt = cnt_nxt == 2'd2 ? STALL : (cnt_nxt == 2'd0 && occ_q == '0) ? IDLE : RUN;
         STALL:   state_nxt = pop ? RUN : STALL;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         occ_q    <= '0;
         in_batch <= 8'd0;
         batch_q  <= 32'd0;
      end else begin
         state <= state_nxt;
         occ_q <= rb_occup;
         if (rd) in_batch <= last_in ? 8'd0 : in_batch + 8'd1;
         if (pop && head[DWIDTH]) batch_q <= batch_q + 32'd1;
      end
   end
   // outputs are forced quiet for as long as reset is held
   assign rb_rd_en  = rd;
   assign out_valid = !rst && fifo_cnt != 2'd0;
   assign out_data  = rst ? '0 : head[DWIDTH-1:0];
   assign out_last  = out_valid && head[DWIDTH];
   assign batch_cnt = rst ? 32'd0 : batch_q;
endmodule

// File: tb/tb_desc_batch_drain.sv
// tb_desc_batch_drain: scoreboard bench against a ring-buffer reference model
module tb_desc_batch_drain;
   import desc_batch_drain_pkg::*;
   localparam int DW = 64;
   localparam int AW = 9;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [DW-1:0] rb_rd_data, out_data, rb_rd_data1, out_data1;
   logic          rb_rd_en, out_valid, out_last, rb_rd_en1, out_valid1, out_last1;
   logic          out_ready = 1'b0;
   logic          out_ready1 = 1'b1;
   logic [AW-1:0] rb_occup, rb_occup1;
   logic [31:0]   batch_cnt, batch_cnt1;
   desc_batch_drain #(.DWIDTH(DW), .AWIDTH(AW), .BATCH_SIZE(8)) dut (
      .clk(clk), .rst(rst), .rb_rd_data(rb_rd_data), .rb_rd_en(rb_rd_en), .rb_occup(rb_occup),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .batch_cnt(batch_cnt));
   desc_batch_drain #(.DWIDTH(DW), .AWIDTH(AW), .BATCH_SIZE(1)) dut1 (
      .clk(clk), .rst(rst), .rb_rd_data(rb_rd_data1), .rb_rd_en(rb_rd_en1), .rb_occup(rb_occup1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
      .batch_cnt(batch_cnt1));
   int n_chk = 0;
   int n_fail = 0;
   function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction
   // ring model: wr_ptr advanced by stimulus, rd_ptr by accepted pops
   logic [DW-1:0] ring [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int in_b = 0;
   typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
   beat_t sb[$];
   assign rb_rd_data = ring[rd_ptr[9:0]];
   assign rb_occup   = AW'(wr_ptr - rd_ptr - int'(rb_rd_en));
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr = wr_ptr;
         in_b = 0;
      end else if (rb_rd_en) begin
         check("pop_nonempty", 64'(wr_ptr - rd_ptr > 0), 64'd1);
         in_b++;
         sb.push_back({ring[rd_ptr[9:0]], in_b == 8 || wr_ptr - rd_ptr == 1});
         if (in_b == 8 || wr_ptr - rd_ptr == 1) in_b = 0;
         rd_ptr++;
      end
   end
   // monitor: compare every accepted beat with the scoreboard head
   int exp_batch = 0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic prev_l;
   beat_t e;
   always @(negedge clk) begin
      if (rst) begin
         exp_batch = 0;
         prev_stall = 1'b0;
      end else begin
         check("batch_cnt", 64'(batch_cnt), 64'(exp_batch));
         if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, prev_d);
            check("hold_last", 64'(out_last), 64'(prev_l));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %0h with nothing expected", out_data);
            end else begin
               e = sb.pop_front();
               check("beat_data", out_data, e.d);
               check("beat_last", 64'(out_last), 64'(e.l));
               if (e.l) exp_batch++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d = out_data;
         prev_l = out_last;
      end
   end
   // single-entry batches: every beat is last, data counts up from 0x100
   int wr1 = 0;
   int rd1 = 0;
   int got1 = 0;
   assign rb_occup1   = AW'(wr1 - rd1 - int'(rb_rd_en1));
   assign rb_rd_data1 = 64'(rd1) + 64'h100;
   always @(posedge clk) if (!rst && rb_rd_en1) rd1++;
   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         check("b1_data", out_data1, 64'(got1) + 64'h100);
         check("b1_last", 64'(out_last1), 64'd1);
         got1++;
      end
   end
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic load(int n);
      for (int i = 0; i < n; i++) begin
         ring[wr_ptr[9:0]] = {32'(wr_ptr), $urandom};
         wr_ptr++;
      end
   endtask
   task automatic drain(string nm);
      int k = 0;
      while (!(wr_ptr == rd_ptr && sb.size() == 0 && !out_valid) && k < 2000) begin
         step();
         k++;
      end
      check({nm, "_drained"}, 64'(k < 2000), 64'd1);
      step(2);
   endtask
   initial begin
      int k;
      int r0;
      step(3);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_last", 64'(out_last), 64'd0);
      check("rst_data", out_data, 64'd0);
      check("rst_rden", 64'(rb_rd_en), 64'd0);
      check("rst_bcnt", 64'(batch_cnt), 64'd0);
      check("rst_state", 64'(dut.state), 64'(IDLE));
      rst = 1'b0;
      step();
      // 20 preloaded entries streamed back to back
      out_ready = 1'b1;
      load(20);
      wr1 = 4;
      k = 0;
      while (!out_valid && k < 10) begin
         step();
         k++;
      end
      for (int i = 0; i < 20; i++) begin
         check("s1_stream", 64'(out_valid), 64'd1);
         step();
      end
      drain("s1");
      check("s1_bcnt", 64'(batch_cnt), 64'd3);
      check("b1_count", 64'(got1), 64'd4);
      check("b1_bcnt", 64'(batch_cnt1), 64'd4);
      // short batch flushed when the ring empties
      load(3);
      drain("s2");
      check("s2_bcnt", 64'(batch_cnt), 64'd4);
      check("s2_idle", 64'(dut.state), 64'(IDLE));
      // downstream stalled: only two reads fit in the output FIFO
      out_ready = 1'b0;
      r0 = rd_ptr;
      load(5);
      step(10);
      check("s3_reads", 64'(rd_ptr - r0), 64'd2);
      check("s3_stall", 64'(dut.state), 64'(STALL));
      check("s3_rden", 64'(rb_rd_en), 64'd0);
      out_ready = 1'b1;
      drain("s3");
      check("s3_reads_all", 64'(rd_ptr - r0), 64'd5);
      check("s3_bcnt", 64'(batch_cnt), 64'd5);
      // ready toggling every cycle
      load(16);
      k = 0;
      while (!(wr_ptr == rd_ptr && sb.size() == 0) && k < 400) begin
         out_ready = ~out_ready;
         step();
         k++;
      end
      out_ready = 1'b1;
      drain("s4");
      check("s4_bcnt", 64'(batch_cnt), 64'd7);
      // reset while the output FIFO is full
      out_ready = 1'b0;
      load(5);
      step(6);
      check("s5_full", 64'(dut.state), 64'(STALL));
      rst = 1'b1;
      sb.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("s5_valid_after_rst", 64'(out_valid), 64'd0);
      check("s5_bcnt_after_rst", 64'(batch_cnt), 64'd0);
      step();
      out_ready = 1'b1;
      load(6);
      drain("s5");
      check("s5_bcnt", 64'(batch_cnt), 64'd1);
      // random arrivals and backpressure
      for (int i = 0; i < 600; i++) begin
         out_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 2) == 0 && wr_ptr - rd_ptr < 200) load($urandom_range(1, 4));
         step();
      end
      out_ready = 1'b1;
      drain("rand");
      check("rand_sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
